// File: rtl/lfsr_seq_pkg.sv
// Shared types and constants for the LFSR step sequencer.
package lfsr_seq_pkg;

    localparam int unsigned LFSR_W     = 4;
    localparam int unsigned STEPS_W    = 3;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned PRESCALE_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DECODE = 2'd2,
        ST_SHOW   = 2'd3
    } seq_state_t;

    localparam logic [LFSR_W-1:0] SEED_A_DEF = 4'b1101;
    localparam logic [LFSR_W-1:0] SEED_B_DEF = 4'b1010;

    // Active-low {a,b,c,d,e,f,g} patterns.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_ONE   = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_TWO   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_THREE = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_FOUR  = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b0000001;

endpackage

// File: rtl/lfsr_pair_step.sv
// One combined step of the coupled LFSR pair; B shifts in the pre-step A[0].
module lfsr_pair_step
    import lfsr_seq_pkg::*;
(
    input  logic [LFSR_W-1:0] a,
    input  logic [LFSR_W-1:0] b,
    output logic [LFSR_W-1:0] a_next,
    output logic [LFSR_W-1:0] b_next
);

    assign a_next = {a[0] ^ ~a[2], a[3:1]};
    assign b_next = {a[0], b[3:1]};

endmodule

// File: rtl/lfsr_step_sequencer.sv
// Steps an LFSR pair a programmed number of times at a prescaled rate, then
// decodes the final pair onto an active-low seven-segment drive.
module lfsr_step_sequencer
    import lfsr_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 20000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LFSR_W-1:0]  seed_a,
    input  logic [LFSR_W-1:0]  seed_b,
    input  logic [STEPS_W-1:0] steps,
    output logic               busy,
    output logic               done,
    output logic [SEG_W-1:0]   seg,
    output logic [LFSR_W-1:0]  lfsr_a,
    output logic [LFSR_W-1:0]  lfsr_b
);

    localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);

    seq_state_t           state, state_n;
    logic [PRESCALE_W-1:0] prescale, prescale_n;
    logic [STEPS_W-1:0]   remaining, remaining_n;
    logic [LFSR_W-1:0]    a_n, b_n, step_a_c, step_b_c;
    logic                 busy_n, done_n;
    logic [SEG_W-1:0]     seg_n, seg_decoded_c;
    logic                 tick_c;

    lfsr_pair_step u_step (
        .a      (lfsr_a),
        .b      (lfsr_b),
        .a_next (step_a_c),
        .b_next (step_b_c)
    );

    assign tick_c = (prescale == TICK_LAST);

    // Final-pair lookup; anything outside the table shows the default pattern.
    always_comb begin
        seg_decoded_c = SEG_ZERO;
        case ({lfsr_a, lfsr_b})
            8'b1101_1101: seg_decoded_c = SEG_ONE;
            8'b1110_1001: seg_decoded_c = SEG_TWO;
            8'b0101_1101: seg_decoded_c = SEG_THREE;
            8'b1010_1111: seg_decoded_c = SEG_FOUR;
            default:      seg_decoded_c = SEG_ZERO;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        prescale_n  = prescale;
        remaining_n = remaining;
        a_n         = lfsr_a;
        b_n         = lfsr_b;
        seg_n       = seg;
        done_n      = 1'b0;
        busy_n      = 1'b0;
        case (state)
            ST_IDLE, ST_SHOW: begin
                if (start) begin
                    a_n         = seed_a;
                    b_n         = seed_b;
                    remaining_n = steps;
                    prescale_n  = '0;
                    state_n     = (steps != '0) ? ST_RUN : ST_DECODE;
                end
            end
            ST_RUN: begin
                if (tick_c) begin
                    prescale_n  = '0;
                    a_n         = step_a_c;
                    b_n         = step_b_c;
                    remaining_n = remaining - STEPS_W'(1);
                    if (remaining == STEPS_W'(1)) begin
                        state_n = ST_DECODE;
                    end
                end else begin
                    prescale_n = prescale + PRESCALE_W'(1);
                end
            end
            ST_DECODE: begin
                seg_n   = seg_decoded_c;
                done_n  = 1'b1;
                state_n = ST_SHOW;
            end
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n == ST_RUN) || (state_n == ST_DECODE);
    end

    // State and output registers; reset blanks the display and reloads default seeds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prescale  <= '0;
            remaining <= '0;
            lfsr_a    <= SEED_A_DEF;
            lfsr_b    <= SEED_B_DEF;
            busy      <= 1'b0;
            done      <= 1'b0;
            seg       <= SEG_BLANK;
        end else begin
            state     <= state_n;
            prescale  <= prescale_n;
            remaining <= remaining_n;
            lfsr_a    <= a_n;
            lfsr_b    <= b_n;
            busy      <= busy_n;
            done      <= done_n;
            seg       <= seg_n;
        end
    end

endmodule

// File: doc/lfsr_step_sequencer.md
LFSR_STEP_SEQUENCER -- requirements
Module: lfsr_step_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 20000000, meaning clk cycles per LFSR step (1 s at 20 MHz Sys_Clk0); legal range 1..2^25-1.
REQ-002 SHALL have port clk  input  1  system clock (Sys_Clk0); all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to run one sequence; sampled every cycle.
REQ-005 SHALL have port seed_a  input  4  initial value of LFSR A; latched on accepted start.
REQ-006 SHALL have port seed_b  input  4  initial value of LFSR B; latched on accepted start.
REQ-007 SHALL have port steps  input  3  number of steps to apply (0..7); latched on accepted start.
REQ-008 SHALL have port busy  output  1  high while in RUN or DECODE.
REQ-009 SHALL have port done  output  1  single-cycle pulse when seg is updated.
REQ-010 SHALL have port seg  output  7  {a,b,c,d,e,f,g}, active-low segment drive, registered.
REQ-011 SHALL have ports lfsr_a, lfsr_b  output  4 each  current register contents, registered.

Function
REQ-012 SHALL implement states IDLE, RUN, DECODE, SHOW.
REQ-013 In IDLE or SHOW, start=1 SHALL latch seeds/steps, clear the prescaler, and go to RUN (steps>0) or DECODE (steps=0).
REQ-014 start SHALL be ignored in RUN and DECODE; no queuing.
REQ-015 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap; the step SHALL occur in the cycle the count equals TICK_DIV-1.
REQ-016 A step SHALL update both registers simultaneously: A <= {A[0]^~A[2], A[3:1]}; B <= {A[0], B[3:1]}, using pre-step A[0].
REQ-017 On the step that takes remaining-steps to 0, the FSM SHALL go to DECODE.
REQ-018 DECODE SHALL last one cycle, then register seg, pulse done, and go to SHOW.
REQ-019 Decode table (A,B -> seg): (1101,1101)->1001111; (1110,1001)->0010010; (0101,1101)->0000110; (1010,1111)->1001100; any other->0000001.
REQ-020 Latency: with start sampled at edge 0, step k SHALL occur at edge k*TICK_DIV, and done/seg SHALL update at edge steps*TICK_DIV+1.
REQ-021 SHOW SHALL hold seg, lfsr_a and lfsr_b until the next accepted start.
REQ-022 A start accepted in SHOW SHALL leave seg unchanged until the new done.
REQ-023 The all-ones A state SHALL be treated as an ordinary value, with no lock-up handling.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, prescaler 0, remaining 0, lfsr_a 1101, lfsr_b 1010, busy 0, done 0, seg 1111111 (blank).
REQ-025 A reset mid-RUN SHALL abort the sequence with no done pulse.
REQ-026 After rst_n deasserts, the first accepted start SHALL be on the first edge with start=1.

Structure
REQ-027 A shared package lfsr_seq_pkg SHALL hold the state enum, default seeds 1101/1010, the SEG_BLANK constant and the five decode-table segment constants.
REQ-028 The step equations SHALL live in one combinational sub-module, lfsr_pair_step (in A,B -> out A,B); the FSM, prescaler and decode stay in the top.

Verification
REQ-029 TICK_DIV=1, seeds 1101/1010, steps=4, start at edge 0 -> steps take A through 1110,0111,1011,0101 and B through 1101,0110,1011,1101; done at edge 5; seg=0000110.
REQ-030 TICK_DIV=3, same seeds, steps=1 -> A=1110, B=1101 at edge 3; done at edge 4; seg=0000001.
REQ-031 steps=0, seeds 1101/1101 -> done one edge after start; seg=1001111; no step occurs.
REQ-032 start held high during RUN -> ignored; exactly one done; busy high from edge 0 until the done edge.
REQ-033 rst_n pulsed low mid-RUN -> immediate seg=1111111, lfsr_a=1101, lfsr_b=1010, busy=0, no done; a new start then completes normally.
REQ-034 start in SHOW with steps=2 -> previous seg holds until the new done, which arrives at edge 2*TICK_DIV+1.
